// File: rtl/conv_win_if.sv
// Pixel-in / window-out bundle for the 3x3 window stage.
// Optional CONV_WIN_CNT_EN adds the per-frame window count signal.
interface conv_win_if #(
    parameter int LINE_W  = 1280,
    parameter int FRAME_H = 720,
    parameter int DW      = 8
);
    localparam int RW = $clog2(FRAME_H);
    localparam int CW = $clog2(LINE_W);
    localparam int NW = $clog2((LINE_W-2)*(FRAME_H-2)+1);

    logic            pix_en;
    logic            sof;
    logic [DW-1:0]   pix_in;
    logic [DW-1:0]   line1_in;
    logic [DW-1:0]   line2_in;
    logic [9*DW-1:0] win;
    logic            win_valid;
    logic [RW-1:0]   win_row;
    logic [CW-1:0]   win_col;
    logic            frame_done;
`ifdef CONV_WIN_CNT_EN
    logic [NW-1:0]   win_count;
`endif

    modport master (
        output pix_en, sof, pix_in, line1_in, line2_in,
        input  win, win_valid, win_row, win_col, frame_done
`ifdef CONV_WIN_CNT_EN
        , input win_count
`endif
    );

    modport slave (
        input  pix_en, sof, pix_in, line1_in, line2_in,
        output win, win_valid, win_row, win_col, frame_done
`ifdef CONV_WIN_CNT_EN
        , output win_count
`endif
    );
endinterface

// File: rtl/conv_window_3x3.sv
// 3x3 sliding window over the line-buffered pixel stream, interior-qualified.
// Define CONV_WIN_CNT_EN to add the per-frame valid-window counter.
module conv_window_3x3 #(
    parameter int LINE_W  = 1280,
    parameter int FRAME_H = 720,
    parameter int DW      = 8
) (
    input  logic       clk,
    input  logic       rst,
    conv_win_if.slave  bus
);
    localparam int RW = $clog2(FRAME_H);
    localparam int CW = $clog2(LINE_W);
`ifdef CONV_WIN_CNT_EN
    localparam int NW = $clog2((LINE_W-2)*(FRAME_H-2)+1);
`endif
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_H-1);
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_W-1);

    logic [RW-1:0] row, cur_row, row_nxt;
    logic [CW-1:0] col, cur_col, col_nxt;
    logic          interior;
    logic          last_pix;
    logic          at_origin;
    logic [DW-1:0] sr [3][3];

    // sof overrides whatever position the counters hold
    always_comb begin
        cur_row   = bus.sof ? '0 : row;
        cur_col   = bus.sof ? '0 : col;
        interior  = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        last_pix  = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        at_origin = (cur_row == '0) && (cur_col == '0);
        row_nxt   = cur_row;
        col_nxt   = cur_col + CW'(1);
        unique case (1'b1)
            last_pix: begin
                row_nxt = '0;
                col_nxt = '0;
            end
            (cur_col == COL_LAST) && !last_pix: begin
                row_nxt = cur_row + RW'(1);
                col_nxt = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (bus.pix_en) begin
            row <= row_nxt;
            col <= col_nxt;
        end
    end

    // Row i=0 is the oldest line; column j=2 is the newest sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    sr[i][j] <= '0;
        end else if (bus.pix_en) begin
            for (int i = 0; i < 3; i++) begin
                sr[i][0] <= sr[i][1];
                sr[i][1] <= sr[i][2];
            end
            sr[0][2] <= bus.line2_in;
            sr[1][2] <= bus.line1_in;
            sr[2][2] <= bus.pix_in;
        end
    end

    always_comb begin
        bus.win = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                bus.win[(3*i+j)*DW +: DW] = sr[i][j];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.win_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.win_row    <= '0;
            bus.win_col    <= '0;
        end else begin
            bus.win_valid  <= bus.pix_en && interior;
            bus.frame_done <= bus.pix_en && last_pix;
            if (bus.pix_en) begin
                bus.win_row <= cur_row - RW'(1);
                bus.win_col <= cur_col - CW'(1);
            end
        end
    end

`ifdef CONV_WIN_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.win_count <= '0;
        end else if (bus.pix_en) begin
            if (at_origin)
                bus.win_count <= '0;
            else if (interior)
                bus.win_count <= bus.win_count + NW'(1);
        end
    end
`else
    logic unused_origin;
    assign unused_origin = at_origin;
`endif
endmodule

// File: tb/tb_conv_window_3x3.sv
// Randomised scenario bench for conv_window_3x3 against an image-array model.
// Build with CONV_WIN_CNT_EN defined to also cover the window counter.
module tb_conv_window_3x3;
    localparam int LW = 8;
    localparam int FH = 6;
    localparam int DW = 8;
    localparam int RW = $clog2(FH);
    localparam int CW = $clog2(LW);
`ifdef CONV_WIN_CNT_EN
    localparam int NW = $clog2((LW-2)*(FH-2)+1);
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_win_if #(.LINE_W(LW), .FRAME_H(FH), .DW(DW)) bus ();

    conv_window_3x3 #(.LINE_W(LW), .FRAME_H(FH), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int errs    = 0;

    logic [DW-1:0]   img [FH][LW];
    int              exp_cnt;
    logic [9*DW-1:0] last_win;
    bit              last_known;
    logic [9*DW-1:0] wins_q [$];
    logic [RW-1:0]   row_q  [$];
    logic [CW-1:0]   col_q  [$];
    logic [RW-1:0]   fd_row;
    logic [CW-1:0]   fd_col;
    logic            fd_valid;

    // Expected taps straight from the frame image
    function automatic logic [9*DW-1:0] model_win(int r, int c);
        logic [9*DW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(3*i+j)*DW +: DW] = img[r-2+i][c-2+j];
        return w;
    endfunction

    task automatic new_image(input bit ramp);
        for (int r = 0; r < FH; r++)
            for (int c = 0; c < LW; c++)
                img[r][c] = ramp ? DW'(8*r+c) : DW'($urandom);
    endtask

    task automatic stream_frame(input bit gapped, input bit first_sof,
                                input int npix,
                                output int nwin, output int nfd);
        int k;
        k    = 0;
        nwin = 0;
        nfd  = 0;
        wins_q.delete();
        row_q.delete();
        col_q.delete();
        while (k < npix) begin
            bit              en, ev, efd;
            int              r, c;
            logic [9*DW-1:0] ew;
            en = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
            r  = k / LW;
            c  = k % LW;
            @(negedge clk);
            bus.pix_en   = en;
            bus.sof      = en ? (first_sof && k == 0)
                              : 1'($urandom_range(0, 1));
            bus.pix_in   = en ? img[r][c] : DW'($urandom);
            bus.line1_in = (en && r >= 1) ? img[r-1][c] : DW'($urandom);
            bus.line2_in = (en && r >= 2) ? img[r-2][c] : DW'($urandom);
            @(posedge clk);
            #1;
            ev  = en && r >= 2 && c >= 2;
            efd = en && r == FH-1 && c == LW-1;
            if (en) begin
                if (r == 0 && c == 0) exp_cnt = 0;
                if (ev) exp_cnt++;
                k++;
            end
            vectors++;
            if (bus.win_valid !== ev || bus.frame_done !== efd) begin
                errs++;
                $display("FAIL qual r%0d c%0d en%0d got v%b fd%b want v%b fd%b",
                         r, c, en, bus.win_valid, bus.frame_done, ev, efd);
            end
            if (ev) begin
                ew = model_win(r, c);
                vectors++;
                if ({bus.win, bus.win_row, bus.win_col} !==
                    {ew, RW'(r-1), CW'(c-1)}) begin
                    errs++;
                    $display("FAIL window r%0d c%0d got %h/%0d/%0d want %h/%0d/%0d",
                             r, c, bus.win, bus.win_row, bus.win_col,
                             ew, r-1, c-1);
                end
                last_win   = ew;
                last_known = 1'b1;
            end else if (!en && last_known) begin
                vectors++;
                if (bus.win !== last_win) begin
                    errs++;
                    $display("FAIL hold got %h want %h", bus.win, last_win);
                end
            end else if (en) begin
                last_known = 1'b0;
            end
`ifdef CONV_WIN_CNT_EN
            vectors++;
            if (bus.win_count !== NW'(exp_cnt)) begin
                errs++;
                $display("FAIL win_count r%0d c%0d got %0d want %0d",
                         r, c, bus.win_count, exp_cnt);
            end
`endif
            if (bus.win_valid) begin
                nwin++;
                wins_q.push_back(bus.win);
                row_q.push_back(bus.win_row);
                col_q.push_back(bus.win_col);
            end
            if (bus.frame_done) begin
                nfd++;
                fd_row   = bus.win_row;
                fd_col   = bus.win_col;
                fd_valid = bus.win_valid;
            end
        end
        @(negedge clk);
        bus.pix_en = 1'b0;
        bus.sof    = 1'b0;
    endtask

    task automatic test_reset();
        bus.pix_en   = 1'b0;
        bus.sof      = 1'b0;
        bus.pix_in   = '0;
        bus.line1_in = '0;
        bus.line2_in = '0;
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.win, bus.win_valid, bus.win_row, bus.win_col,
             bus.frame_done} !== '0) begin
            errs++;
            $display("FAIL reset_outs got %h/%b/%0d/%0d/%b want 0",
                     bus.win, bus.win_valid, bus.win_row, bus.win_col,
                     bus.frame_done);
        end
`ifdef CONV_WIN_CNT_EN
        vectors++;
        if (bus.win_count !== '0) begin
            errs++;
            $display("FAIL reset_count got %0d want 0", bus.win_count);
        end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        exp_cnt    = 0;
        last_known = 1'b0;
    endtask

    task automatic test_ramp();
        int              nw, nf;
        logic [9*DW-1:0] w;
        new_image(1'b1);
        stream_frame(1'b0, 1'b0, LW*FH, nw, nf);
        vectors++;
        if (nw != 24 || nf != 1) begin
            errs++;
            $display("FAIL ramp_counts got %0d/%0d want 24/1", nw, nf);
        end
        vectors++;
        if (wins_q.size() == 0) begin
            errs++;
            $display("FAIL ramp_first got none want 1");
        end else begin
            w = wins_q[0];
            if (w[0 +: DW] !== 8'd0 || w[8*DW +: DW] !== 8'd18 ||
                row_q[0] !== RW'(1) || col_q[0] !== CW'(1)) begin
                errs++;
                $display("FAIL ramp_first got %h r%0d c%0d want t00=0 t22=18 r1 c1",
                         w, row_q[0], col_q[0]);
            end
        end
        vectors++;
        if (fd_row !== RW'(4) || fd_col !== CW'(6) || fd_valid !== 1'b1) begin
            errs++;
            $display("FAIL ramp_done got r%0d c%0d v%b want r4 c6 v1",
                     fd_row, fd_col, fd_valid);
        end
    endtask

    task automatic test_line_wrap();
        int              nw, nf;
        logic [9*DW-1:0] w;
        new_image(1'b1);
        stream_frame(1'b0, 1'b0, LW*FH, nw, nf);
        vectors++;
        if (wins_q.size() < 7) begin
            errs++;
            $display("FAIL wrap_count got %0d want 24", wins_q.size());
        end else begin
            w = wins_q[6];
            if (w[6*DW +: DW] !== 8'd24 || w[8*DW +: DW] !== 8'd26 ||
                row_q[6] !== RW'(2) || col_q[6] !== CW'(1)) begin
                errs++;
                $display("FAIL wrap_row3 got %h r%0d c%0d want t20=24 t22=26 r2 c1",
                         w, row_q[6], col_q[6]);
            end
        end
    endtask

    task automatic test_gapped();
        int nw, nf;
        new_image(1'b0);
        stream_frame(1'b1, 1'b0, LW*FH, nw, nf);
        vectors++;
        if (nw != 24 || nf != 1) begin
            errs++;
            $display("FAIL gapped_counts got %0d/%0d want 24/1", nw, nf);
        end
    endtask

    task automatic test_mid_sof();
        int nw, nf;
        new_image(1'b0);
        stream_frame(1'b0, 1'b0, 3*LW+5, nw, nf);
        new_image(1'b0);
        stream_frame(1'b0, 1'b1, LW*FH, nw, nf);
        vectors++;
        if (nw != 24 || nf != 1) begin
            errs++;
            $display("FAIL sof_counts got %0d/%0d want 24/1", nw, nf);
        end
    endtask

    task automatic test_async_reset();
        int nw, nf;
        new_image(1'b0);
        stream_frame(1'b1, 1'b0, 20, nw, nf);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.win, bus.win_valid, bus.win_row, bus.win_col,
             bus.frame_done} !== '0) begin
            errs++;
            $display("FAIL async_rst got %h/%b/%0d/%0d/%b want 0",
                     bus.win, bus.win_valid, bus.win_row, bus.win_col,
                     bus.frame_done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        exp_cnt    = 0;
        last_known = 1'b0;
        new_image(1'b0);
        stream_frame(1'b0, 1'b0, LW*FH, nw, nf);
        vectors++;
        if (nw != 24 || nf != 1) begin
            errs++;
            $display("FAIL post_rst_counts got %0d/%0d want 24/1", nw, nf);
        end
    endtask

`ifdef CONV_WIN_CNT_EN
    task automatic test_win_count();
        int nw, nf;
        new_image(1'b0);
        stream_frame(1'b0, 1'b0, LW*FH, nw, nf);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (bus.win_count !== NW'(24) || bus.win_valid !== 1'b0) begin
                errs++;
                $display("FAIL count_hold got %0d v%b want 24 v0",
                         bus.win_count, bus.win_valid);
            end
        end
        new_image(1'b0);
        stream_frame(1'b1, 1'b0, LW*FH, nw, nf);
        vectors++;
        if (bus.win_count !== NW'(24) || nf != 1) begin
            errs++;
            $display("FAIL count_frame2 got %0d/%0d want 24/1",
                     bus.win_count, nf);
        end
    endtask
`endif

    initial begin
        exp_cnt    = 0;
        last_known = 1'b0;
        fd_row     = '0;
        fd_col     = '0;
        fd_valid   = 1'b0;
        test_reset();
        test_ramp();
        test_line_wrap();
        test_gapped();
        test_mid_sof();
        test_async_reset();
`ifdef CONV_WIN_CNT_EN
        test_win_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
